// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch core.
package stopwatch_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_FULL  = 3'd4
  } state_t;

  localparam logic [3:0]  DIGIT_MAX  = 4'd9;
  localparam logic [3:0]  TENS_MAX   = 4'd5;
  localparam logic [15:0] LED_ALL_ON = 16'hFFFF;
  localparam logic [15:0] CNT_PRESAT = 16'h5958;
endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit of the stopwatch count; wraps MAX->0 and flags carry on that step.
module bcd_digit_ctr #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);
  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = 4'd0;
    else if (inc) q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= 4'd0;
    else        q_q <= q_d;
  end

  assign q     = q_q;
  assign carry = inc && (q_q == MAX);
endmodule

// File: rtl/stopwatch_ctl.sv
// Count-up mm:ss stopwatch with start/pause, lap freeze and clear.
// Define STOPWATCH_WRAP_EN to roll 59:59 -> 00:00 with a sticky wrap flag instead of saturating.
module stopwatch_ctl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pb_start,
  input  logic        pb_lap,
  input  logic        pb_clear,
  output logic [3:0]  val0,
  output logic [3:0]  val1,
  output logic [3:0]  val2,
  output logic [3:0]  val3,
  output logic        running,
  output logic        lap_active,
  output logic        full,
  output logic [15:0] led
);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [15:0]     lap_q, lap_d;
  logic            wrap_q, wrap_d;
  logic            running_q, lap_active_q, full_q;
  logic [15:0]     led_q, led_d;
  logic [3:0][3:0] dig;
  logic [4:0]      inc_c;
  logic            counting, tick, clr_cnt;

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = counting && (div_q == DW'(TICK_DIV - 1));
  assign clr_cnt  = pb_clear && ((state_q == ST_PAUSE) || (state_q == ST_FULL));
  assign inc_c[0] = tick;

  // Digits 0..3 = s1, s10, m1, m10; tens digits stop at 5.
  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit_ctr #(.MAX((i % 2) ? TENS_MAX : DIGIT_MAX)) u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_cnt),
      .inc   (inc_c[i]),
      .q     (dig[i]),
      .carry (inc_c[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lap_d   = lap_q;
    wrap_d  = wrap_q;
    if (counting) div_d = tick ? '0 : div_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (pb_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pb_start) state_d = ST_PAUSE;
        else if (pb_lap) begin
          state_d = ST_LAP;
          lap_d   = dig;
        end
      end
      ST_LAP: begin
        if (pb_start)    state_d = ST_PAUSE;
        else if (pb_lap) state_d = ST_RUN;
      end
      ST_PAUSE, ST_FULL: begin
        if (pb_clear) begin
          state_d = ST_IDLE;
          div_d   = '0;
          lap_d   = '0;
          wrap_d  = 1'b0;
        end else if (pb_start && state_q == ST_PAUSE) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The minutes-tens carry only fires when the count rolls over 59:59.
    if (inc_c[4]) wrap_d = 1'b1;
`ifndef STOPWATCH_WRAP_EN
    if (tick && dig == CNT_PRESAT) state_d = ST_FULL;
`endif
  end

  always_comb begin
    led_d = 16'h0000;
    if (state_d == ST_FULL) led_d = LED_ALL_ON;
    else begin
      led_d[0] = (state_d == ST_RUN) || (state_d == ST_LAP);
      led_d[1] = (state_d == ST_LAP);
      led_d[2] = (state_d == ST_PAUSE);
`ifdef STOPWATCH_WRAP_EN
      led_d[15] = wrap_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      lap_q        <= '0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      full_q       <= 1'b0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      lap_q        <= lap_d;
      wrap_q       <= wrap_d;
      running_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_active_q <= (state_d == ST_LAP);
      full_q       <= (state_d == ST_FULL) || wrap_d;
      led_q        <= led_d;
    end
  end

  assign {val3, val2, val1, val0} = (state_q == ST_LAP) ? lap_q : dig;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign full       = full_q;
  assign led        = led_q;
endmodule
